// File: rtl/dm_pkg.sv
// Shared definitions for the dual-port memory arbiter: FSM state encoding
// and port-index constants.
package dm_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } dm_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/dm_starve_cnt.sv
// Saturating starvation counter: counts cycles the loader port is held off,
// flags when the limit is reached.
module dm_starve_cnt #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  assign at_max = (cnt == CW'(LIMIT));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of a single synchronous-read memory: CPU port has
// priority, the loader port is promoted after STARVE_MAX lost cycles.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  input  logic [3:0]    p0_be,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [31:0]   p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  input  logic [3:0]    p1_be,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [31:0]   p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_wea,
  output logic [31:0]   mem_din,
  input  logic [31:0]   mem_dout
);

  dm_state_t     state, state_nxt;
  logic          rd_owner, rd_owner_nxt;
  logic          rd_pend;
  logic          at_max;
  logic [AW-1:0] addr_q;

  dm_starve_cnt #(.LIMIT(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (p1_req && p0_gnt),
    .clr    (p1_gnt || !p1_req),
    .at_max (at_max)
  );

  // Grant selection and read-tracking FSM; reset masks every grant.
  always_comb begin
    p0_gnt       = 1'b0;
    p1_gnt       = 1'b0;
    rd_owner_nxt = rd_owner;
    state_nxt    = IDLE;
    if (!rst) begin
      if (p1_req && (at_max || !p0_req)) begin
        p1_gnt = 1'b1;
      end else if (p0_req) begin
        p0_gnt = 1'b1;
      end
    end
    if (p0_gnt && !p0_we) begin
      state_nxt    = RD_WAIT;
      rd_owner_nxt = PORT_CPU;
    end else if (p1_gnt && !p1_we) begin
      state_nxt    = RD_WAIT;
      rd_owner_nxt = PORT_LDR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rd_owner <= PORT_CPU;
      addr_q   <= '0;
    end else begin
      state    <= state_nxt;
      rd_owner <= rd_owner_nxt;
      if (p0_gnt) begin
        addr_q <= p0_addr;
      end else if (p1_gnt) begin
        addr_q <= p1_addr;
      end
    end
  end

  // Memory-side mux; the address holds between grants so the RAM sees no glitches.
  always_comb begin
    mem_addr = rst ? '0 : addr_q;
    mem_din  = '0;
    mem_wea  = 4'b0000;
    if (p0_gnt) begin
      mem_addr = p0_addr;
      mem_din  = p0_wdata;
      mem_wea  = p0_we ? p0_be : 4'b0000;
    end else if (p1_gnt) begin
      mem_addr = p1_addr;
      mem_din  = p1_wdata;
      mem_wea  = p1_we ? p1_be : 4'b0000;
    end
  end

  assign rd_pend   = (state == RD_WAIT);
  assign p0_rvalid = !rst && rd_pend && (rd_owner == PORT_CPU);
  assign p1_rvalid = !rst && rd_pend && (rd_owner == PORT_LDR);
  assign p0_rdata  = p0_rvalid ? mem_dout : 32'h0;
  assign p1_rdata  = p1_rvalid ? mem_dout : 32'h0;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a small byte-lane memory model behind it.
module tb_dm_arbiter;

  logic        clk;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic [3:0]  p0_be, p1_be;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic [3:0]  mem_wea;

  logic [31:0] mem [0:255];

  int errors = 0;
  int checks = 0;

  dm_arbiter #(.STARVE_MAX(4), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wea(mem_wea), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-before-write synchronous RAM with byte-lane enables.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_wea[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_din[b*8 +: 8];
    end
    mem_dout <= mem[mem_addr[9:2]];
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_be = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_be = 0;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    next_cycle;
    set_idle;
    p1_req = 1; p1_we = 1; p1_addr = a; p1_wdata = d; p1_be = 4'b1111;
  endtask

  task automatic test_reset;
    rst = 1;
    set_idle;
    p0_req = 1; p0_addr = 32'h10; p1_req = 1; p1_addr = 32'h4;
    next_cycle;
    next_cycle;
    #2;
    checks++; if (p0_gnt !== 1'b0) begin errors++; $display("[TB] FAIL rst_p0_gnt got=%0h exp=0", p0_gnt); end
    checks++; if (p1_gnt !== 1'b0) begin errors++; $display("[TB] FAIL rst_p1_gnt got=%0h exp=0", p1_gnt); end
    checks++; if ({p0_rvalid, p1_rvalid} !== 2'b00) begin errors++; $display("[TB] FAIL rst_rvalid got=%b exp=00", {p0_rvalid, p1_rvalid}); end
    checks++; if (mem_wea !== 4'b0000) begin errors++; $display("[TB] FAIL rst_wea got=%h exp=0", mem_wea); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_addr got=%h exp=0", mem_addr); end
    next_cycle;
    rst = 0;
    p1_req = 0;
    #2;
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("[TB] FAIL first_gnt got=%0h exp=1", p0_gnt); end
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("[TB] FAIL first_addr got=%h exp=10", mem_addr); end
  endtask

  task automatic test_p1_write;
    next_cycle;
    set_idle;
    p1_req = 1; p1_we = 1; p1_addr = 32'h102; p1_be = 4'b1100; p1_wdata = 32'h1234_1234;
    #2;
    checks++; if (p1_gnt !== 1'b1) begin errors++; $display("[TB] FAIL wr_p1_gnt got=%0h exp=1", p1_gnt); end
    checks++; if (mem_wea !== 4'b1100) begin errors++; $display("[TB] FAIL wr_wea got=%b exp=1100", mem_wea); end
    checks++; if (mem_addr !== 32'h102) begin errors++; $display("[TB] FAIL wr_addr got=%h exp=102", mem_addr); end
    checks++; if (mem_din !== 32'h1234_1234) begin errors++; $display("[TB] FAIL wr_din got=%h exp=12341234", mem_din); end
    next_cycle;
    set_idle;
    #2;
    checks++; if ({p0_rvalid, p1_rvalid} !== 2'b00) begin errors++; $display("[TB] FAIL wr_no_rvalid got=%b exp=00", {p0_rvalid, p1_rvalid}); end
    checks++; if (mem[8'h40][31:16] !== 16'h1234) begin errors++; $display("[TB] FAIL wr_mem got=%h exp=1234", mem[8'h40][31:16]); end
    checks++; if (mem_din !== 32'h0) begin errors++; $display("[TB] FAIL idle_din got=%h exp=0", mem_din); end
    checks++; if (mem_addr !== 32'h102) begin errors++; $display("[TB] FAIL idle_addr_hold got=%h exp=102", mem_addr); end
  endtask

  task automatic test_p0_read;
    next_cycle;
    set_idle;
    p0_req = 1; p0_addr = 32'h10;
    #2;
    checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin errors++; $display("[TB] FAIL rd_gnt got=%b exp=10", {p0_gnt, p1_gnt}); end
    checks++; if (mem_wea !== 4'b0000) begin errors++; $display("[TB] FAIL rd_wea got=%b exp=0000", mem_wea); end
    next_cycle;
    set_idle;
    #2;
    checks++; if (p0_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL rd_rvalid got=%0h exp=1", p0_rvalid); end
    checks++; if (p0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL rd_data got=%h exp=deadbeef", p0_rdata); end
    checks++; if (p1_rvalid !== 1'b0 || p1_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rd_p1_quiet got=%0h/%h exp=0/0", p1_rvalid, p1_rdata); end
    next_cycle;
    #2;
    checks++; if (p0_rvalid !== 1'b0 || p0_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rd_after got=%0h/%h exp=0/0", p0_rvalid, p0_rdata); end
  endtask

  task automatic test_back_to_back;
    next_cycle;
    set_idle;
    p0_req = 1; p0_addr = 32'h0;
    #2;
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("[TB] FAIL b2b_g0 got=%0h exp=1", p0_gnt); end
    next_cycle;
    set_idle;
    p1_req = 1; p1_addr = 32'h4;
    #2;
    checks++; if (p1_gnt !== 1'b1) begin errors++; $display("[TB] FAIL b2b_g1 got=%0h exp=1", p1_gnt); end
    checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h1111_1111) begin errors++; $display("[TB] FAIL b2b_r0 got=%0h/%h exp=1/11111111", p0_rvalid, p0_rdata); end
    next_cycle;
    set_idle;
    p0_req = 1; p0_addr = 32'h8;
    #2;
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("[TB] FAIL b2b_g2 got=%0h exp=1", p0_gnt); end
    checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== 32'h2222_2222 || p0_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_r1 got=%0h/%h p0v=%0h exp=1/22222222 p0v=0", p1_rvalid, p1_rdata, p0_rvalid); end
    next_cycle;
    set_idle;
    #2;
    checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h3333_3333 || p1_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_r2 got=%0h/%h p1v=%0h exp=1/33333333 p1v=0", p0_rvalid, p0_rdata, p1_rvalid); end
  endtask

  task automatic test_write_during_read;
    next_cycle;
    set_idle;
    p0_req = 1; p0_addr = 32'h10;
    next_cycle;
    set_idle;
    p1_req = 1; p1_we = 1; p1_addr = 32'h10; p1_be = 4'b1111; p1_wdata = 32'hCAFE_F00D;
    #2;
    checks++; if (p1_gnt !== 1'b1) begin errors++; $display("[TB] FAIL wdr_gnt got=%0h exp=1", p1_gnt); end
    checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL wdr_old got=%0h/%h exp=1/deadbeef", p0_rvalid, p0_rdata); end
    next_cycle;
    set_idle;
    p0_req = 1; p0_addr = 32'h10;
    next_cycle;
    set_idle;
    #2;
    checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL wdr_new got=%0h/%h exp=1/cafef00d", p0_rvalid, p0_rdata); end
  endtask

  task automatic test_starvation;
    logic prev_p0;
    next_cycle;
    set_idle;
    prev_p0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_cycle;
      p0_req = 1; p0_addr = 32'h0;
      p1_req = 1; p1_addr = 32'h4;
      #2;
      checks++;
      if (int'(dut.u_starve.cnt) != (i % 5)) begin errors++; $display("[TB] FAIL starve_cnt[%0d] got=%0d exp=%0d", i, dut.u_starve.cnt, i % 5); end
      checks++;
      if ({p0_gnt, p1_gnt} !== (((i % 5) == 4) ? 2'b01 : 2'b10)) begin errors++; $display("[TB] FAIL starve_gnt[%0d] got=%b exp=%b", i, {p0_gnt, p1_gnt}, ((i % 5) == 4) ? 2'b01 : 2'b10); end
      if (i > 0) begin
        checks++;
        if (prev_p0 && (p0_rvalid !== 1'b1 || p0_rdata !== 32'h1111_1111)) begin errors++; $display("[TB] FAIL starve_r0[%0d] got=%0h/%h exp=1/11111111", i, p0_rvalid, p0_rdata); end
        else if (!prev_p0 && (p1_rvalid !== 1'b1 || p1_rdata !== 32'h2222_2222)) begin errors++; $display("[TB] FAIL starve_r1[%0d] got=%0h/%h exp=1/22222222", i, p1_rvalid, p1_rdata); end
      end
      prev_p0 = ((i % 5) != 4);
    end
  endtask

  task automatic test_zero_be;
    next_cycle;
    set_idle;
    p0_req = 1; p0_we = 1; p0_addr = 32'h4; p0_be = 4'b0000; p0_wdata = 32'hFFFF_FFFF;
    #2;
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("[TB] FAIL zbe_gnt got=%0h exp=1", p0_gnt); end
    checks++; if (mem_wea !== 4'b0000) begin errors++; $display("[TB] FAIL zbe_wea got=%b exp=0000", mem_wea); end
    next_cycle;
    set_idle;
    #2;
    checks++; if (mem[1] !== 32'h2222_2222) begin errors++; $display("[TB] FAIL zbe_mem got=%h exp=22222222", mem[1]); end
    checks++; if (p0_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL zbe_rvalid got=%0h exp=0", p0_rvalid); end
  endtask

  task automatic test_reset_mid_read;
    next_cycle;
    set_idle;
    p0_req = 1; p0_addr = 32'h10;
    #2;
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("[TB] FAIL rmr_gnt got=%0h exp=1", p0_gnt); end
    next_cycle;
    set_idle;
    rst = 1;
    p1_req = 1; p1_addr = 32'h4;
    #2;
    checks++; if (p0_rvalid !== 1'b0 || p0_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rmr_rvalid got=%0h/%h exp=0/0", p0_rvalid, p0_rdata); end
    checks++; if ({p0_gnt, p1_gnt, p1_rvalid} !== 3'b000) begin errors++; $display("[TB] FAIL rmr_gnt_rst got=%b exp=000", {p0_gnt, p1_gnt, p1_rvalid}); end
    checks++; if (mem_wea !== 4'b0000 || mem_addr !== 32'h0 || mem_din !== 32'h0) begin errors++; $display("[TB] FAIL rmr_mem got=%b/%h/%h exp=0/0/0", mem_wea, mem_addr, mem_din); end
    next_cycle;
    rst = 0;
    #2;
    checks++; if ({p0_gnt, p1_gnt} !== 2'b01) begin errors++; $display("[TB] FAIL rmr_p1_gnt got=%b exp=01", {p0_gnt, p1_gnt}); end
    checks++; if (p0_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rmr_late_rvalid got=%0h exp=0", p0_rvalid); end
    next_cycle;
    set_idle;
    #2;
    checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== 32'h2222_2222) begin errors++; $display("[TB] FAIL rmr_p1_data got=%0h/%h exp=1/22222222", p1_rvalid, p1_rdata); end
  endtask

  initial begin
    rst = 1;
    set_idle;
    test_reset;
    load_word(32'h10, 32'hDEAD_BEEF);
    load_word(32'h0,  32'h1111_1111);
    load_word(32'h4,  32'h2222_2222);
    load_word(32'h8,  32'h3333_3333);
    test_p1_write;
    test_p0_read;
    test_back_to_back;
    test_write_during_read;
    test_starvation;
    test_zero_be;
    test_reset_mid_read;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
